// File: rtl/video_fetch_arbiter.sv
// rtl/video_fetch_arbiter.sv - shares one 17-bit SRAM port between the CPU and the character video fetch
//
// Purpose:
//   Each character slot with display enable launches an atomic pair of SRAM reads:
//   the screen code from VRAM, then the glyph row from the character ROM.
//   The row is handed to the pixel shifter on the following character strobe.
//   CPU accesses are served in the gaps. An access in flight is never preempted.
//
// Optional build macro: INVERSE_VIDEO_EN
//   When defined, code[6:0] indexes a 1 KiB glyph window and code[7] inverts the row.
//
// Ports:
//   clk_i, reset_ni               clock and synchronous active-low reset
//   cclk_en_i, de_i, ma_i, ra_i   CRTC character strobe, display enable, addresses
//   cpu_req_i/we_i/addr_i/wdata_i CPU request; the CPU holds it until cpu_ack_o
//   cpu_ack_o                     1-cycle completion; read data is on mem_rdata_i
//   mem_req_o/we_o/addr_o/wdata_o SRAM request; held until mem_done_i
//   mem_done_i, mem_rdata_i       SRAM completion pulse and read data
//   pixels_o, pixels_load_o       pixel byte (MSB first) and shifter load strobe
//   underrun_o                    previous slot's fetch did not finish in time
module video_fetch_arbiter #(
  parameter logic [16:0] VRAM_BASE    = 17'h08000,
  parameter logic [16:0] CHARROM_BASE = 17'h10000
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        cclk_en_i,
  input  logic        de_i,
  input  logic [13:0] ma_i,
  input  logic [4:0]  ra_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [16:0] cpu_addr_i,
  input  logic [7:0]  cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [16:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic        mem_done_i,
  input  logic [7:0]  mem_rdata_i,
  output logic [7:0]  pixels_o,
  output logic        pixels_load_o,
  output logic        underrun_o
);

  typedef enum logic [1:0] {S_IDLE, S_CPU, S_V_CODE, S_V_ROW} state_t;

  state_t      state_q, state_d;
  logic        vid_pending;
  logic [9:0]  ma_q;
  logic [2:0]  ra_q;
  logic [9:0]  fetch_ma;
  logic [2:0]  fetch_ra;
  logic [7:0]  code_q;
  logic [7:0]  row_q;
  logic        fetch_ok;
  logic        de_last;
  logic [7:0]  row_fmt;
  logic        slot_go;
  logic        vid_want;
  logic        row_done;
  logic        unused_bits;

  assign unused_bits = ^{ma_i[13:10], ra_i[4:3]};

  assign slot_go  = cclk_en_i & de_i;
  // A slot arriving this very cycle counts as pending, so video beats a waiting CPU.
  assign vid_want = vid_pending | slot_go;
  assign row_done = (state_q == S_V_ROW) & mem_done_i;

  // The row is stored already formatted, so a later code fetch cannot alter it.
`ifdef INVERSE_VIDEO_EN
  assign row_fmt = code_q[7] ? ~mem_rdata_i : mem_rdata_i;
`else
  assign row_fmt = mem_rdata_i;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (vid_want) begin
          state_d = S_V_CODE;
        end else if (cpu_req_i) begin
          state_d = S_CPU;
        end
      end
      S_CPU:    if (mem_done_i) state_d = S_IDLE;
      S_V_CODE: if (mem_done_i) state_d = S_V_ROW;
      S_V_ROW:  if (mem_done_i) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      vid_pending <= 1'b0;
      ma_q        <= '0;
      ra_q        <= '0;
      fetch_ma    <= '0;
      fetch_ra    <= '0;
      code_q      <= '0;
      row_q       <= '0;
      fetch_ok    <= 1'b0;
      de_last     <= 1'b0;
    end else begin
      if (row_done) begin
        row_q       <= row_fmt;
        vid_pending <= 1'b0;
      end
      // A new slot overrides completion of the old one in the same cycle.
      if (slot_go) begin
        vid_pending <= 1'b1;
        ma_q        <= ma_i[9:0];
        ra_q        <= ra_i[2:0];
      end
      // Snapshot the address at launch so a missed slot cannot move an in-flight fetch.
      if ((state_q == S_IDLE) && vid_want) begin
        fetch_ma <= slot_go ? ma_i[9:0] : ma_q;
        fetch_ra <= slot_go ? ra_i[2:0] : ra_q;
      end
      if ((state_q == S_V_CODE) && mem_done_i) begin
        code_q <= mem_rdata_i;
      end
      // A completion on the strobe cycle is consumed by the bypass, so it never sets fetch_ok.
      if (cclk_en_i) begin
        fetch_ok <= 1'b0;
        de_last  <= de_i;
      end else if (row_done) begin
        fetch_ok <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    cpu_ack_o     = 1'b0;
    pixels_load_o = cclk_en_i;
    pixels_o      = 8'h00;
    underrun_o    = 1'b0;

    case (state_q)
      S_CPU: begin
        mem_req_o   = 1'b1;
        mem_we_o    = cpu_we_i;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        cpu_ack_o   = mem_done_i;
      end
      S_V_CODE: begin
        mem_req_o  = 1'b1;
        mem_addr_o = VRAM_BASE + {7'd0, fetch_ma};
      end
      S_V_ROW: begin
        mem_req_o  = 1'b1;
`ifdef INVERSE_VIDEO_EN
        mem_addr_o = CHARROM_BASE + {7'd0, code_q[6:0], fetch_ra};
`else
        mem_addr_o = CHARROM_BASE + {6'd0, code_q, fetch_ra};
`endif
      end
      default: ;
    endcase

    if (cclk_en_i) begin
      if (row_done) begin
        pixels_o = row_fmt;
      end else if (fetch_ok) begin
        pixels_o = row_q;
      end
      underrun_o = de_last & ~fetch_ok & ~row_done;
    end
  end

endmodule

// File: tb/tb_video_fetch_arbiter.sv
// tb/tb_video_fetch_arbiter.sv - scoreboard bench for video_fetch_arbiter
module tb_video_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic        cclk_en = 1'b0;
  logic        de = 1'b0;
  logic [13:0] ma = '0;
  logic [4:0]  ra = '0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [16:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        mem_done = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        cpu_ack_o, mem_req_o, mem_we_o, pixels_load_o, underrun_o;
  logic [16:0] mem_addr_o;
  logic [7:0]  mem_wdata_o, pixels_o;

  always #5 clk = ~clk;

  video_fetch_arbiter dut (
    .clk_i(clk), .reset_ni(reset_ni), .cclk_en_i(cclk_en), .de_i(de),
    .ma_i(ma), .ra_i(ra), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata), .cpu_ack_o(cpu_ack_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_done_i(mem_done), .mem_rdata_i(mem_rdata),
    .pixels_o(pixels_o), .pixels_load_o(pixels_load_o), .underrun_o(underrun_o)
  );

  typedef struct {logic [16:0] addr; logic we; logic [7:0] wdata;} acc_t;
  typedef struct {logic rd; logic [7:0] data;} ack_t;

  logic [7:0] sram [0:131071];
  acc_t       exp_acc[$];
  logic [8:0] exp_pix[$];
  ack_t       exp_ack[$];
  int         n_vec = 0;
  int         n_bad = 0;
  bit         auto_mem = 1'b0;
  int         mem_lat = 1;
  int         wcnt = 0;

`ifdef INVERSE_VIDEO_EN
  localparam logic [16:0] T6_ROW_ADDR = 17'h1020B;
  localparam logic [7:0]  T6_PIX      = 8'hC3;
`else
  localparam logic [16:0] T6_ROW_ADDR = 17'h1060B;
  localparam logic [7:0]  T6_PIX      = 8'h5A;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: event seen or missing where scoreboard disagrees", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_acc(input logic [16:0] a, input logic w, input logic [7:0] d);
    acc_t e;
    e.addr = a; e.we = w; e.wdata = d;
    exp_acc.push_back(e);
  endtask

  task automatic slot(input bit d, input logic [13:0] a, input logic [4:0] r,
                      input logic [7:0] px, input bit un);
    exp_pix.push_back({un, px});
    cclk_en = 1'b1; de = d; ma = a; ra = r;
    step();
    cclk_en = 1'b0; de = 1'b0;
  endtask

  task automatic cpu_access(input bit w, input logic [16:0] a, input logic [7:0] wd,
                            input logic [7:0] rd_exp);
    ack_t e;
    int   n;
    e.rd = !w; e.data = rd_exp;
    exp_ack.push_back(e);
    cpu_req = 1'b1; cpu_we = w; cpu_addr = a; cpu_wdata = wd;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ack_o && n < 500);
    if (!cpu_ack_o) fail_evt("cpu_ack timeout");
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  // SRAM model: answers after mem_lat idle cycles while auto_mem is set.
  initial forever begin
    step();
    if (auto_mem) begin
      if (mem_done) begin
        mem_done = 1'b0;
        wcnt = 0;
      end else if (mem_req_o) begin
        if (wcnt >= mem_lat) begin
          mem_done = 1'b1;
          mem_rdata = sram[mem_addr_o];
          if (mem_we_o) sram[mem_addr_o] = mem_wdata_o;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: every new SRAM access, pixel load and CPU ack is matched against the queues.
  logic prev_req = 1'b0;
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    acc_t a;
    ack_t k;
    logic [8:0] p;
    if (mem_req_o && (!prev_req || prev_done)) begin
      if (exp_acc.size() == 0) begin
        fail_evt("unexpected mem access");
      end else begin
        a = exp_acc.pop_front();
        chk("mem_addr", mem_addr_o, a.addr);
        chk("mem_we", mem_we_o, a.we);
        if (a.we) chk("mem_wdata", mem_wdata_o, a.wdata);
      end
    end
    prev_req  = mem_req_o;
    prev_done = mem_done;
    if (pixels_load_o) begin
      if (exp_pix.size() == 0) begin
        fail_evt("unexpected pixel load");
      end else begin
        p = exp_pix.pop_front();
        chk("pixels", pixels_o, p[7:0]);
        chk("underrun", underrun_o, p[8]);
      end
    end else if (underrun_o) begin
      fail_evt("underrun without load");
    end
    if (cpu_ack_o) begin
      if (exp_ack.size() == 0) begin
        fail_evt("unexpected cpu_ack");
      end else begin
        k = exp_ack.pop_front();
        chk("ack_we", mem_we_o, !k.rd);
        if (k.rd) chk("cpu rdata", mem_rdata, k.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 131072; i++) sram[i] = 8'h00;
    sram[17'h08005] = 8'h41; sram[17'h1020B] = 8'h3C;
    sram[17'h08007] = 8'h12; sram[17'h10091] = 8'hA5;
    sram[17'h08006] = 8'hC1; sram[17'h1060B] = 8'h5A;
    sram[17'h00100] = 8'h77;

    // Reset state
    repeat (3) step();
    chk("rst mem_req", mem_req_o, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    chk("rst outputs", {cpu_ack_o, mem_we_o, pixels_load_o, underrun_o, pixels_o}, 0);
    reset_ni = 1'b1;
    step();

    // 1: reset abandons an in-flight video fetch
    auto_mem = 1'b0;
    push_acc(17'h08005, 1'b0, 8'h00);
    slot(1'b1, 14'h0005, 5'd3, 8'h00, 1'b0);
    chk("t1 req in V_CODE", mem_req_o, 1);
    reset_ni = 1'b0;
    step();
    chk("t1 req after reset", mem_req_o, 0);
    chk("t1 addr after reset", mem_addr_o, 0);
    chk("t1 outs after reset", {cpu_ack_o, mem_we_o, underrun_o, pixels_o}, 0);
    reset_ni = 1'b1;
    mem_done = 1'b1; mem_rdata = 8'h41;
    step();
    chk("t1 late done ignored", {cpu_ack_o, mem_req_o}, 0);
    mem_done = 1'b0;
    repeat (3) step();
    chk("t1 stays idle", mem_req_o, 0);
    slot(1'b0, 14'h0000, 5'd0, 8'h00, 1'b0);

    // 2: basic video fetch
    auto_mem = 1'b1; mem_lat = 1;
    push_acc(17'h08005, 1'b0, 8'h00);
    push_acc(17'h1020B, 1'b0, 8'h00);
    slot(1'b1, 14'h0005, 5'd3, 8'h00, 1'b0);
    repeat (12) step();
    slot(1'b0, 14'h0000, 5'd0, 8'h3C, 1'b0);
    slot(1'b0, 14'h0000, 5'd0, 8'h00, 1'b0);

    // 3: pending CPU request loses to a slot arriving in IDLE
    push_acc(17'h08007, 1'b0, 8'h00);
    push_acc(17'h10091, 1'b0, 8'h00);
    push_acc(17'h00100, 1'b0, 8'h00);
    fork
      slot(1'b1, 14'h0007, 5'd1, 8'h00, 1'b0);
      cpu_access(1'b0, 17'h00100, 8'h00, 8'h77);
    join
    repeat (4) step();
    slot(1'b0, 14'h0000, 5'd0, 8'hA5, 1'b0);

    // 4: CPU in flight finishes first; the video pair stays atomic
    mem_lat = 4;
    push_acc(17'h00200, 1'b1, 8'h99);
    push_acc(17'h08005, 1'b0, 8'h00);
    push_acc(17'h1020B, 1'b0, 8'h00);
    push_acc(17'h00100, 1'b0, 8'h00);
    fork
      begin
        cpu_access(1'b1, 17'h00200, 8'h99, 8'h00);
        cpu_access(1'b0, 17'h00100, 8'h00, 8'h77);
      end
      begin
        step();
        slot(1'b1, 14'h0005, 5'd3, 8'h00, 1'b0);
      end
    join
    repeat (4) step();
    slot(1'b0, 14'h0000, 5'd0, 8'h3C, 1'b0);
    chk("t4 sram write", sram[17'h00200], 8'h99);
    mem_lat = 1;

    // 5a: slow SRAM -> underrun on the next slot, late row shown on the one after
    mem_lat = 20;
    push_acc(17'h08005, 1'b0, 8'h00);
    push_acc(17'h1020B, 1'b0, 8'h00);
    slot(1'b1, 14'h0005, 5'd3, 8'h00, 1'b0);
    repeat (3) step();
    slot(1'b1, 14'h0005, 5'd3, 8'h00, 1'b1);
    repeat (50) step();
    slot(1'b0, 14'h0000, 5'd0, 8'h3C, 1'b0);
    mem_lat = 1;
    repeat (3) step();

    // 5b: row completion on the strobe cycle is bypassed to the shifter
    auto_mem = 1'b0;
    push_acc(17'h08007, 1'b0, 8'h00);
    push_acc(17'h10091, 1'b0, 8'h00);
    slot(1'b1, 14'h0007, 5'd1, 8'h00, 1'b0);
    step();
    mem_done = 1'b1; mem_rdata = 8'h12;
    step();
    mem_done = 1'b0;
    repeat (2) step();
    exp_pix.push_back({1'b0, 8'hA5});
    mem_done = 1'b1; mem_rdata = 8'hA5; cclk_en = 1'b1; de = 1'b0;
    step();
    mem_done = 1'b0; cclk_en = 1'b0;
    step();
    chk("t5 idle after bypass", mem_req_o, 0);
    slot(1'b0, 14'h0000, 5'd0, 8'h00, 1'b0);

    // 6: screen code with bit 7 set
    auto_mem = 1'b1;
    push_acc(17'h08006, 1'b0, 8'h00);
    push_acc(T6_ROW_ADDR, 1'b0, 8'h00);
    slot(1'b1, 14'h0006, 5'd3, 8'h00, 1'b0);
    repeat (10) step();
    slot(1'b0, 14'h0000, 5'd0, T6_PIX, 1'b0);

    repeat (5) step();
    chk("access queue drained", exp_acc.size(), 0);
    chk("pixel queue drained", exp_pix.size(), 0);
    chk("ack queue drained", exp_ack.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
